// File: rtl/led_pwm_controller_if.sv
// rtl/led_pwm_controller_if.sv - Avalon-MM register bus bundle for the LED controller
interface led_pwm_controller_if;
    logic        WRITE;
    logic        READ;
    logic [7:0]  ADDR;
    logic [31:0] WDATA;
    logic [31:0] RDATA;

    modport master (output WRITE, READ, ADDR, WDATA, input RDATA);
    modport slave  (input WRITE, READ, ADDR, WDATA, output RDATA);
endinterface

// File: rtl/led_pwm_controller.sv
// rtl/led_pwm_controller.sv - per-channel off/on/blink/PWM LED driver with Avalon-MM registers
module led_pwm_controller #(
    parameter int N_LED    = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 50000
) (
    input  logic                 CLK,
    input  logic                 RST,
    led_pwm_controller_if.slave  bus,
    output logic [N_LED-1:0]     LED
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [N_LED-1:0]    enable_q, enable_d;
    logic [2*N_LED-1:0]  mode_q, mode_d;
    logic [15:0]         half_q, half_d;
    logic [PWM_BITS-1:0] duty_q [N_LED];
    logic [PWM_BITS-1:0] duty_d [N_LED];
    logic [PW-1:0]       presc_q, presc_d;
    logic [15:0]         blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [N_LED-1:0]    led_q, led_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         rd_val;
    logic                tick;
    logic                half_wr;
    logic                unused_wdata;

    assign tick         = (presc_q == PW'(PRESCALE - 1));
    assign unused_wdata = ^bus.WDATA;
    assign LED          = led_q;
    assign bus.RDATA    = rdata_q;

    always_comb begin
        enable_d    = enable_q;
        mode_d      = mode_q;
        half_d      = half_q;
        duty_d      = duty_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        rdata_d     = rdata_q;
        led_d       = '0;
        rd_val      = '0;
        half_wr     = 1'b0;
        presc_d     = tick ? '0 : presc_q + 1'b1;
        pwm_d       = pwm_q + 1'b1;

        if (bus.WRITE) begin
            case (bus.ADDR)
                8'h00: enable_d = bus.WDATA[N_LED-1:0];
                8'h01: mode_d   = bus.WDATA[2*N_LED-1:0];
                8'h02: begin
                    half_d  = bus.WDATA[15:0];
                    half_wr = 1'b1;
                end
                default: ;
            endcase
            for (int i = 0; i < N_LED; i++) begin
                if (bus.ADDR == 8'(16 + i)) duty_d[i] = bus.WDATA[PWM_BITS-1:0];
            end
        end

        // A BLINK_HALF write beats a coincident tick; writing 0 parks the phase dark at once.
        if (half_wr) begin
            blink_cnt_d = '0;
            if (half_d == 16'd0) phase_d = 1'b0;
        end else if (half_q == 16'd0) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == half_q - 16'd1) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end

        for (int i = 0; i < N_LED; i++) begin
            case (mode_q[2*i +: 2])
                2'd0:    led_d[i] = 1'b0;
                2'd1:    led_d[i] = enable_q[i];
                2'd2:    led_d[i] = enable_q[i] & phase_q;
                default: led_d[i] = enable_q[i] & (pwm_q < duty_q[i]);
            endcase
        end

        // Reads sample the pre-write register state, so read+write returns the old value.
        case (bus.ADDR)
            8'h00:   rd_val[N_LED-1:0]   = enable_q;
            8'h01:   rd_val[2*N_LED-1:0] = mode_q;
            8'h02:   rd_val[15:0]        = half_q;
            8'h03:   rd_val              = {blink_cnt_q, 15'd0, phase_q};
            default: ;
        endcase
        for (int i = 0; i < N_LED; i++) begin
            if (bus.ADDR == 8'(16 + i)) rd_val[PWM_BITS-1:0] = duty_q[i];
        end
        if (bus.READ) rdata_d = rd_val;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            enable_q    <= '1;
            mode_q      <= (2*N_LED)'(1);
            half_q      <= 16'h01F4;
            duty_q      <= '{default: '0};
            presc_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            pwm_q       <= '0;
            led_q       <= N_LED'(1);
            rdata_q     <= '0;
        end else begin
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            half_q      <= half_d;
            duty_q      <= duty_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pwm_q       <= pwm_d;
            led_q       <= led_d;
            rdata_q     <= rdata_d;
        end
    end
endmodule

// File: tb/tb_led_pwm_controller.sv
// tb/tb_led_pwm_controller.sv - directed bench with cycle-level reference model for led_pwm_controller
module tb_led_pwm_controller;
    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic [N-1:0] LED;

    led_pwm_controller_if bus ();

    led_pwm_controller #(.N_LED(N), .PWM_BITS(4), .PRESCALE(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus),
        .LED (LED)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: timebases derived from the number of edges since reset.
    logic [7:0]  m_en;
    logic [15:0] m_mode;
    logic [15:0] m_half;
    logic [3:0]  m_duty [N];
    int unsigned m_e;
    int unsigned m_tt;
    logic        m_pref;
    logic [7:0]  exp_led;
    logic [31:0] exp_rdata;
    bit          model_ok = 0;
    logic        m_ph;
    logic [15:0] m_cnt;
    logic [1:0]  m_m;
    logic [31:0] m_rv;

    function automatic logic cur_phase();
        if (m_half == 16'd0) return 1'b0;
        return m_pref ^ logic'((m_tt / m_half) % 2);
    endfunction

    function automatic logic [15:0] cur_count();
        if (m_half == 16'd0) return 16'd0;
        return 16'(m_tt % m_half);
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_en      = 8'hFF;
            m_mode    = 16'h0001;
            m_half    = 16'h01F4;
            for (int i = 0; i < N; i++) m_duty[i] = 4'd0;
            m_e       = 0;
            m_tt      = 0;
            m_pref    = 1'b0;
            exp_led   = 8'h01;
            exp_rdata = 32'd0;
            model_ok  = 1;
        end else if (model_ok) begin
            m_ph  = cur_phase();
            m_cnt = cur_count();
            for (int i = 0; i < N; i++) begin
                m_m = m_mode[2*i +: 2];
                if (m_m == 2'd0)      exp_led[i] = 1'b0;
                else if (m_m == 2'd1) exp_led[i] = m_en[i];
                else if (m_m == 2'd2) exp_led[i] = m_en[i] & m_ph;
                else                  exp_led[i] = m_en[i] & ((m_e % 16) < m_duty[i]);
            end
            if (bus.READ) begin
                m_rv = 32'd0;
                if (bus.ADDR == 8'h00) m_rv = {24'd0, m_en};
                else if (bus.ADDR == 8'h01) m_rv = {16'd0, m_mode};
                else if (bus.ADDR == 8'h02) m_rv = {16'd0, m_half};
                else if (bus.ADDR == 8'h03) m_rv = {m_cnt, 15'd0, m_ph};
                else if (bus.ADDR >= 8'h10 && bus.ADDR < 8'h18) m_rv = {28'd0, m_duty[bus.ADDR - 8'h10]};
                exp_rdata = m_rv;
            end
            if (bus.WRITE && bus.ADDR == 8'h02) begin
                m_half = bus.WDATA[15:0];
                m_tt   = 0;
                m_pref = (m_half == 16'd0) ? 1'b0 : m_ph;
            end else if ((m_e % 4) == 3 && m_half != 16'd0) begin
                m_tt++;
            end
            if (bus.WRITE) begin
                if (bus.ADDR == 8'h00) m_en = bus.WDATA[7:0];
                else if (bus.ADDR == 8'h01) m_mode = bus.WDATA[15:0];
                else if (bus.ADDR >= 8'h10 && bus.ADDR < 8'h18) m_duty[bus.ADDR - 8'h10] = bus.WDATA[3:0];
            end
            m_e++;
        end
    end

    always @(negedge CLK) begin
        if (model_ok) begin
            n_tests++;
            if (LED !== exp_led) begin
                n_fail++;
                $display("FAIL led_model t=%0t: LED=%h expected %h", $time, LED, exp_led);
            end
            n_tests++;
            if (bus.RDATA !== exp_rdata) begin
                n_fail++;
                $display("FAIL rdata_model t=%0t: RDATA=%h expected %h", $time, bus.RDATA, exp_rdata);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.ADDR  = a;
        bus.WDATA = d;
        bus.WRITE = 1'b1;
        @(negedge CLK);
        bus.WRITE = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        bus.ADDR = a;
        bus.READ = 1'b1;
        @(negedge CLK);
        bus.READ = 1'b0;
        d = bus.RDATA;
    endtask

    task automatic wait_toggle(input int ch, output int cycles);
        logic prev;
        prev   = LED[ch];
        cycles = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            cycles++;
            if (LED[ch] != prev) return;
        end
        cycles = -1;
    endtask

    task automatic count_high(input int ch, input int len, output int highs);
        highs = 0;
        for (int k = 0; k < len; k++) begin
            @(negedge CLK);
            if (LED[ch]) highs++;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          cyc;
        int          hi;

        RST       = 1'b1;
        bus.WRITE = 1'b0;
        bus.READ  = 1'b0;
        bus.ADDR  = 8'h00;
        bus.WDATA = 32'd0;
        repeat (3) @(negedge CLK);
        check("reset_led", 32'(LED), 32'h01);
        check("reset_rdata", bus.RDATA, 32'h0);
        RST = 1'b0;

        rd(8'h00, d); check("reset_enable", d, 32'hFF);
        rd(8'h01, d); check("reset_mode", d, 32'h1);
        rd(8'h02, d); check("reset_blink_half", d, 32'h1F4);
        for (int i = 0; i < N; i++) begin
            rd(8'(16 + i), d);
            check($sformatf("reset_duty%0d", i), d, 32'h0);
        end

        wr(8'h01, 32'h5555);
        @(negedge CLK);
        check("mode_all_on", 32'(LED), 32'hFF);
        wr(8'h00, 32'h0F);
        @(negedge CLK);
        check("enable_low_nibble", 32'(LED), 32'h0F);

        wr(8'h00, 32'hFF);
        wr(8'h01, 32'h20);
        wr(8'h02, 32'd3);
        wait_toggle(2, cyc);
        wait_toggle(2, cyc);
        check("blink_interval_a", 32'(cyc), 32'd12);
        wait_toggle(2, cyc);
        check("blink_interval_b", 32'(cyc), 32'd12);
        wr(8'h02, 32'd0);
        count_high(2, 40, hi);
        check("blink_half0_dark", 32'(hi), 32'd0);
        rd(8'h03, d);
        check("blink_half0_phase", 32'(d[0]), 32'd0);
        check("blink_half0_status", d, 32'd0);

        wr(8'h01, 32'h0C);
        wr(8'h11, 32'd5);
        @(negedge CLK);
        count_high(1, 16, hi);
        check("pwm_duty5", 32'(hi), 32'd5);
        wr(8'h11, 32'd0);
        @(negedge CLK);
        count_high(1, 16, hi);
        check("pwm_duty0", 32'(hi), 32'd0);
        wr(8'h11, 32'd15);
        @(negedge CLK);
        count_high(1, 32, hi);
        check("pwm_duty15", 32'(hi), 32'd30);

        bus.ADDR  = 8'h00;
        bus.WDATA = 32'h3;
        bus.READ  = 1'b1;
        bus.WRITE = 1'b1;
        @(negedge CLK);
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
        check("rw_same_addr_old", bus.RDATA, 32'hFF);
        rd(8'h00, d); check("rw_same_addr_new", d, 32'h03);
        rd(8'h7F, d); check("unmapped_read", d, 32'h0);
        wr(8'h18, 32'hA);
        rd(8'h18, d); check("oob_duty_read", d, 32'h0);
        rd(8'h11, d); check("oob_keeps_duty1", d, 32'hF);
        rd(8'h10, d); check("oob_keeps_duty0", d, 32'h0);
        rd(8'h00, d); check("oob_keeps_enable", d, 32'h3);
        rd(8'h01, d); check("oob_keeps_mode", d, 32'hC);

        wr(8'h00, 32'hFF);
        wr(8'h01, 32'h2C);
        wr(8'h02, 32'd3);
        repeat (20) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_led", 32'(LED), 32'h01);
        check("midrst_rdata", bus.RDATA, 32'h0);
        RST = 1'b0;
        rd(8'h03, d); check("midrst_status", d, 32'h0);
        repeat (4) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_pwm_controller.md
# led_pwm_controller

Parametrised Avalon-MM slave driving N_LED indicator outputs, each independently configurable as off, on, blinking or PWM-dimmed. Successor to the single-register LED latch: it adds per-channel modes, a prescaled blink timebase, per-channel PWM duty and full register readback. It sits on the board-control Avalon bus, and its LED outputs export through a conduit to the board pins.

## Interface
Parameters:
- N_LED, 8, number of LED channels; legal range 1..16.
- PWM_BITS, 8, width of the PWM counter and duty registers; legal range 1..16.
- PRESCALE, 50000, CLK cycles per blink tick; must be ≥ 2.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- WRITE  in  1  Avalon write strobe.
- READ  in  1  Avalon read strobe.
- ADDR  in  8  Avalon word address.
- WDATA  in  32  write data.
- RDATA  out  32  read data, registered.
- LED  out  N_LED  LED drive, registered; 1 = lit.

## Operation
Register map (word addresses). Unused bits read 0. Unmapped reads return 0; unmapped writes are ignored.
- 0x00 ENABLE[N_LED-1:0]: per-channel enable; a disabled channel drives 0. Reset value: all ones.
- 0x01 MODE[2*N_LED-1:0]: channel i uses bits [2i+1:2i]. Encoding: 0 = off, 1 = on, 2 = blink, 3 = PWM. Reset value: channel 0 = on, all others off (0x1).
- 0x02 BLINK_HALF[15:0]: blink half-period in ticks. Reset value: 0x01F4. Writing this register clears the blink tick counter; the blink phase is unchanged.
- 0x03 STATUS (read-only): bit0 = blink phase; bits[31:16] = current blink tick count.
- 0x10+i DUTY_i[PWM_BITS-1:0], for i < N_LED: PWM duty of channel i. Reset value: 0.

Prescaler:
- Counts 0..PRESCALE-1 and wraps.
- Asserts a one-cycle tick when the count equals PRESCALE-1.

Blink timebase:
- On each tick, the tick counter increments.
- When the counter equals BLINK_HALF-1, the counter clears to 0 and the phase toggles.
- BLINK_HALF = 0: counter and phase are held at 0, so blink channels stay dark.

PWM:
- A free-running PWM_BITS counter increments every CLK and wraps at 2^PWM_BITS-1 → 0.
- Channel output = (pwm_cnt < DUTY_i), an unsigned compare.
- DUTY = 0 gives always off; DUTY = 2^PWM_BITS-1 gives on for all but one cycle per period.

Output:
- LED[i] = ENABLE[i] & sel(MODE_i) per the mode encoding, registered.
- Reset value of LED = 1 (channel 0 lit as a power indicator). Reset value of RDATA = 0.
- Reset clears all counters and the blink phase.

## Timing
- Write: on the edge where WRITE=1, the register is updated. LED reflects the new setting on the following edge (1-cycle latency).
- Read: fixed read latency of 1. RDATA is valid on the edge after READ=1 and holds until the next READ.
- Simultaneous READ and WRITE to the same address: RDATA returns the pre-write value.
- Simultaneous tick and BLINK_HALF write: the write wins; the counter clears and the phase does not toggle.
- BLINK_HALF written to a value ≤ the current count cannot occur, because a write always clears the count.
- A MODE change takes effect at LED one cycle later, regardless of PWM or blink phase. There is no glitch suppression.
- RST asserted mid-operation: all registers and counters take their reset values on that edge. LED = 1 from the next edge. Any pending read data is discarded (RDATA = 0).
- Blink period = 2 × BLINK_HALF × PRESCALE cycles. PWM period = 2^PWM_BITS cycles.

## Test plan
- Reset check: assert RST for 3 cycles, then release. Required: LED=0x01, RDATA=0; reads return ENABLE=0xFF, MODE=0x1, BLINK_HALF=0x1F4, DUTY_i=0.
- Static mode and enable: write MODE=0x5555 (all channels on), then ENABLE=0x0F. Required: LED=0xFF one cycle after the MODE write, then 0x0F one cycle after the ENABLE write.
- Blink (PRESCALE=4): write BLINK_HALF=3 and MODE channel 2 = blink. Required: LED[2] toggles every 12 CLK cycles. With BLINK_HALF=0, LED[2]=0 permanently and STATUS bit0=0.
- PWM (PWM_BITS=4): write DUTY_1=5 and MODE channel 1 = PWM. Required: LED[1] high for exactly 5 of every 16 cycles. Also check DUTY=0 gives 0 cycles high and DUTY=15 gives 15 cycles high.
- Bus corner cases: READ and WRITE together at 0x00 with WDATA=0x3. Required: RDATA is the old 0xFF, and the next read returns 0x03. A read of 0x7F returns 0. A write to 0x10+N_LED leaves all registers unchanged.
- Mid-operation reset: assert RST during blink plus PWM activity. Required: LED=0x01 on the next cycle, and STATUS=0 after release.
